// File: rtl/ex_alu_seq_pkg.sv
// Shared ALU control codes, LEGv8 opcode constants and the ALUOp/opcode decoder
// used by the EX-stage ALU and its iterative multiply/divide unit.
package ex_alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_LSL, ALU_LSR,
    ALU_PASS, ALU_MUL, ALU_SDIV, ALU_UDIV
  } alu_op_e;

  typedef enum logic [1:0] {MD_MUL, MD_SDIV, MD_UDIV} md_op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ANDS = 11'b11101010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_DIV  = 11'b10011010110;

  // I-format opcodes are 10 bits; instruction bit 21 belongs to the immediate.
  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;

  localparam logic [5:0] SHAMT_SDIV = 6'b000010;
  localparam logic [5:0] SHAMT_UDIV = 6'b000011;

  function automatic alu_op_e decode(input logic [1:0] aluop, input logic [10:0] opc,
                                     input logic [5:0] shamt);
    alu_op_e    op;
    logic [9:0] opi;
    opi = opc[10:1];
    op  = ALU_NONE;
    case (aluop)
      2'b00: op = ALU_ADD;
      2'b01: op = ALU_PASS;
      2'b10: begin
        if (opc == OP_ADD || opc == OP_ADDS || opi == OP_ADDI || opi == OP_ADDIS)
          op = ALU_ADD;
        else if (opc == OP_SUB || opc == OP_SUBS || opi == OP_SUBI || opi == OP_SUBIS)
          op = ALU_SUB;
        else if (opc == OP_AND || opc == OP_ANDS || opi == OP_ANDI || opi == OP_ANDIS)
          op = ALU_AND;
        else if (opc == OP_ORR || opi == OP_ORRI)
          op = ALU_OR;
        else if (opc == OP_LSL)
          op = ALU_LSL;
        else if (opc == OP_LSR)
          op = ALU_LSR;
        else if (opc == OP_MUL)
          op = ALU_MUL;
        else if (opc == OP_DIV && shamt == SHAMT_SDIV)
          op = ALU_SDIV;
        else if (opc == OP_DIV && shamt == SHAMT_UDIV)
          op = ALU_UDIV;
      end
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, ITER_BITS bits per cycle.
// done pulses in the final iteration cycle, with res already holding the answer.
module ex_muldiv_iter
  import ex_alu_seq_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ITER_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  md_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] res
);

  localparam int NITER = DATA_W / ITER_BITS;
  localparam int CW    = $clog2(NITER);
  localparam logic [CW-1:0]   LAST  = CW'(NITER - 1);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic              run;
  logic [CW-1:0]     cnt;
  logic              is_div, neg, bzero;
  logic [DATA_W-1:0] acc, mcand, mplier, quo, dvs;
  logic [DATA_W-1:0] acc_n, mcand_n, mplier_n, quo_n;
  logic [DATA_W:0]   rem, rem_n;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? (~x + ONE) : x;
  endfunction

  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      rem    <= '0;
      quo    <= mag(a, op == MD_SDIV);
      dvs    <= mag(b, op == MD_SDIV);
      is_div <= (op != MD_MUL);
      neg    <= (op == MD_SDIV) && (a[DATA_W-1] ^ b[DATA_W-1]);
      bzero  <= (b == '0);
    end else if (run) begin
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      rem    <= rem_n;
      quo    <= quo_n;
    end
  end

  // Quotient register doubles as the dividend shifter: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    rem_n    = rem;
    quo_n    = quo;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (mplier_n[0]) acc_n = acc_n + mcand_n;
      mcand_n  = mcand_n << 1;
      mplier_n = mplier_n >> 1;
      rem_n    = {rem_n[DATA_W-1:0], quo_n[DATA_W-1]};
      quo_n    = quo_n << 1;
      if (rem_n >= {1'b0, dvs}) begin
        rem_n    = rem_n - {1'b0, dvs};
        quo_n[0] = 1'b1;
      end
    end
    if (!is_div)    res = acc_n;
    else if (bzero) res = '0;
    else if (neg)   res = ~quo_n + ONE;
    else            res = quo_n;
  end

endmodule

// File: rtl/ex_alu_seq.sv
// EX-stage ALU: LEGv8 decode, single-cycle ALU with NZCV, multi-cycle MUL/DIV
// via ex_muldiv_iter, valid/ready on both sides and flush for branch squash.
module ex_alu_seq
  import ex_alu_seq_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ITER_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [10:0]       opcode,
  input  logic [5:0]        shamt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              busy
);

  if ((DATA_W % 2) != 0 || DATA_W < 8 || !(ITER_BITS == 1 || ITER_BITS == 2)) begin : g_param_check
    $error("ex_alu_seq: DATA_W must be even and >= 8, ITER_BITS must be 1 or 2");
  end

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W:0] ONE_X = (DATA_W + 1)'(1);

  state_e                   state;
  alu_op_e                  op_dec;
  md_op_e                   md_op;
  logic                     accept, md_start, md_done;
  logic [DATA_W-1:0]        md_res;
  logic signed [DATA_W-1:0] alu_res;
  logic [DATA_W:0]          sum;
  logic                     c_flag, v_flag;

  function automatic logic [3:0] mk_flags(input logic [DATA_W-1:0] r, input logic c,
                                          input logic v);
    return {r[DATA_W-1], (r == '0), c, v};
  endfunction

  assign op_dec   = decode(ALUOp, opcode, shamt);
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign md_start = accept && (op_dec == ALU_MUL || op_dec == ALU_SDIV || op_dec == ALU_UDIV);

  always_comb begin
    md_op = MD_MUL;
    if (op_dec == ALU_SDIV)      md_op = MD_SDIV;
    else if (op_dec == ALU_UDIV) md_op = MD_UDIV;
  end

  // Single-cycle datapath; SUB is a + ~b + 1 so C reads as no-borrow.
  always_comb begin
    alu_res = '0;
    sum     = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (op_dec)
      ALU_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[DATA_W-1:0];
        c_flag  = sum[DATA_W];
        v_flag  = (a[DATA_W-1] == b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        sum     = {1'b0, a} + {1'b0, ~b} + ONE_X;
        alu_res = sum[DATA_W-1:0];
        c_flag  = sum[DATA_W];
        v_flag  = (a[DATA_W-1] != b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_LSL:  alu_res = a << b[SH_W-1:0];
      ALU_LSR:  alu_res = a >> b[SH_W-1:0];
      ALU_PASS: alu_res = b;
      default:  alu_res = '0;
    endcase
  end

  ex_muldiv_iter #(.DATA_W(DATA_W), .ITER_BITS(ITER_BITS)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res)
  );

  // Output register stage: loaded on single-cycle accept or in the final
  // iteration cycle; DONE is the one cycle the long result is presented before IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_dec == ALU_MUL) begin
              state <= S_MUL;
              busy  <= 1'b1;
            end else if (op_dec == ALU_SDIV || op_dec == ALU_UDIV) begin
              state <= S_DIV;
              busy  <= 1'b1;
            end else begin
              result    <= alu_res;
              flags     <= mk_flags(alu_res, c_flag, v_flag);
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (md_done) begin
            result    <= md_res;
            flags     <= mk_flags(md_res, 1'b0, 1'b0);
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
